aibcr3_iobuf_seq: RTL and testbench

- Per-pad configuration sequencer that owns the static control inputs of one AIB IO buffer digital slice: pad reset, digital reset, TX enable, P/N drive strength, RX enable mode and weak pulls.
- Applies a requested configuration through a fixed, glitch-safe order: quiesce, release pad reset, apply drive/RX, enable TX and release digital reset. A programmable settle time separates each step.
- Sits between the channel configuration registers and the IO buffer slice; one instance per pad.

---
 rtl/aibcr3_iobuf_seq.sv | 242 ++++++++++++++++++++++++
 tb/tb_aibcr3_iobuf_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aibcr3_iobuf_seq.sv
// aibcr3_iobuf_seq
//   Per-pad configuration sequencer for one AIB IO buffer digital slice.
//   A four-phase request (icfg_req/ocfg_ack) applies a snapshot of the
//   icfg_* fields in a fixed, glitch-safe order:
//     quiesce -> release pad reset -> apply drive/RX -> enable TX and
//     release digital reset -> acknowledge.
//   Each of the four steps lasts isettle_cnt+1 cycles, with isettle_cnt
//   captured when the request is accepted.
//
// Ports
//   iclk, irstb           sequencer clock, async active-low reset
//   icfg_req / ocfg_ack   four-phase handshake
//   icfg_tx_en/rxen/pdrv/ndrv/wkpu/wkpd
//                         requested slice configuration
//   isettle_cnt           settle cycles per step, minus 1
//   obusy                 high in every state except IDLE
//   opad_rstb, odig_rstb, otx_en, oipdrv, oindrv, oirxen,
//   otest_weakpu, otest_weakpd
//                         registered controls into the IO buffer slice
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for icfg_req, outputs hold the last configuration
// QUIESCE  | TX off, drives off, RX off, both resets asserted
// PADREL   | pad reset released
// DRIVE    | drive strengths and RX mode applied
// TXON     | TX enable applied, digital reset released
// DONE     | ack high until icfg_req is sampled low

module aibcr3_iobuf_seq #(
  parameter int         CNT_W    = 8,
  parameter logic [2:0] RXEN_OFF = 3'b000
) (
  input  logic             iclk,
  input  logic             irstb,
  input  logic             icfg_req,
  input  logic             icfg_tx_en,
  input  logic [2:0]       icfg_rxen,
  input  logic [1:0]       icfg_pdrv,
  input  logic [1:0]       icfg_ndrv,
  input  logic             icfg_wkpu,
  input  logic             icfg_wkpd,
  input  logic [CNT_W-1:0] isettle_cnt,
  output logic             ocfg_ack,
  output logic             obusy,
  output logic             opad_rstb,
  output logic             odig_rstb,
  output logic             otx_en,
  output logic [1:0]       oipdrv,
  output logic [1:0]       oindrv,
  output logic [2:0]       oirxen,
  output logic             otest_weakpu,
  output logic             otest_weakpd
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUIESCE = 3'd1,
    ST_PADREL  = 3'd2,
    ST_DRIVE   = 3'd3,
    ST_TXON    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Snapshot of the accepted request; later icfg_* changes are ignored.
  logic               snap_tx_q, snap_tx_d;
  logic [2:0]         snap_rxen_q, snap_rxen_d;
  logic [1:0]         snap_pdrv_q, snap_pdrv_d;
  logic [1:0]         snap_ndrv_q, snap_ndrv_d;
  logic [CNT_W-1:0]   snap_n_q, snap_n_d;

  logic               ack_q, ack_d;
  logic               pad_rstb_q, pad_rstb_d;
  logic               dig_rstb_q, dig_rstb_d;
  logic               tx_en_q, tx_en_d;
  logic [1:0]         pdrv_q, pdrv_d;
  logic [1:0]         ndrv_q, ndrv_d;
  logic [2:0]         rxen_q, rxen_d;
  logic               wkpu_q, wkpu_d;
  logic               wkpd_q, wkpd_d;

  logic               step_done;

  assign step_done = (cnt_q == '0);

  always_ff @(posedge iclk or negedge irstb) begin
    if (!irstb) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      snap_tx_q   <= 1'b0;
      snap_rxen_q <= RXEN_OFF;
      snap_pdrv_q <= 2'b00;
      snap_ndrv_q <= 2'b00;
      snap_n_q    <= '0;
      ack_q       <= 1'b0;
      pad_rstb_q  <= 1'b0;
      dig_rstb_q  <= 1'b0;
      tx_en_q     <= 1'b0;
      pdrv_q      <= 2'b00;
      ndrv_q      <= 2'b00;
      rxen_q      <= RXEN_OFF;
      wkpu_q      <= 1'b0;
      wkpd_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      snap_tx_q   <= snap_tx_d;
      snap_rxen_q <= snap_rxen_d;
      snap_pdrv_q <= snap_pdrv_d;
      snap_ndrv_q <= snap_ndrv_d;
      snap_n_q    <= snap_n_d;
      ack_q       <= ack_d;
      pad_rstb_q  <= pad_rstb_d;
      dig_rstb_q  <= dig_rstb_d;
      tx_en_q     <= tx_en_d;
      pdrv_q      <= pdrv_d;
      ndrv_q      <= ndrv_d;
      rxen_q      <= rxen_d;
      wkpu_q      <= wkpu_d;
      wkpd_q      <= wkpd_d;
    end
  end

  // Outputs are written on the edge that enters a state, so each step's
  // values are visible from that state's first cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    snap_tx_d   = snap_tx_q;
    snap_rxen_d = snap_rxen_q;
    snap_pdrv_d = snap_pdrv_q;
    snap_ndrv_d = snap_ndrv_q;
    snap_n_d    = snap_n_q;
    ack_d       = ack_q;
    pad_rstb_d  = pad_rstb_q;
    dig_rstb_d  = dig_rstb_q;
    tx_en_d     = tx_en_q;
    pdrv_d      = pdrv_q;
    ndrv_d      = ndrv_q;
    rxen_d      = rxen_q;
    wkpu_d      = wkpu_q;
    wkpd_d      = wkpd_q;

    case (state_q)
      ST_IDLE: begin
        if (icfg_req) begin
          state_d     = ST_QUIESCE;
          cnt_d       = isettle_cnt;
          snap_tx_d   = icfg_tx_en;
          snap_rxen_d = icfg_rxen;
          snap_pdrv_d = icfg_pdrv;
          snap_ndrv_d = icfg_ndrv;
          snap_n_d    = isettle_cnt;
          tx_en_d     = 1'b0;
          pdrv_d      = 2'b00;
          ndrv_d      = 2'b00;
          rxen_d      = RXEN_OFF;
          dig_rstb_d  = 1'b0;
          pad_rstb_d  = 1'b0;
          // Pull-up wins a conflicting request so the pad is never
          // pulled both ways.
          wkpu_d      = icfg_wkpu;
          wkpd_d      = icfg_wkpd & ~icfg_wkpu;
        end
      end

      ST_QUIESCE: begin
        if (!step_done) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d    = ST_PADREL;
          cnt_d      = snap_n_q;
          pad_rstb_d = 1'b1;
        end
      end

      ST_PADREL: begin
        if (!step_done) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_DRIVE;
          cnt_d   = snap_n_q;
          pdrv_d  = snap_pdrv_q;
          ndrv_d  = snap_ndrv_q;
          rxen_d  = snap_rxen_q;
        end
      end

      ST_DRIVE: begin
        if (!step_done) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d    = ST_TXON;
          cnt_d      = snap_n_q;
          tx_en_d    = snap_tx_q;
          dig_rstb_d = 1'b1;
          // Weak pulls only matter while the driver is off.
          if (snap_tx_q) begin
            wkpu_d = 1'b0;
            wkpd_d = 1'b0;
          end
        end
      end

      ST_TXON: begin
        if (!step_done) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
        end
      end

      ST_DONE: begin
        if (!icfg_req) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  assign ocfg_ack     = ack_q;
  assign obusy        = (state_q != ST_IDLE);
  assign opad_rstb    = pad_rstb_q;
  assign odig_rstb    = dig_rstb_q;
  assign otx_en       = tx_en_q;
  assign oipdrv       = pdrv_q;
  assign oindrv       = ndrv_q;
  assign oirxen       = rxen_q;
  assign otest_weakpu = wkpu_q;
  assign otest_weakpd = wkpd_q;

endmodule

// File: tb/tb_aibcr3_iobuf_seq.sv
module tb_aibcr3_iobuf_seq;

  logic       iclk = 1'b0;
  logic       irstb;
  logic       icfg_req;
  logic       icfg_tx_en;
  logic [2:0] icfg_rxen;
  logic [1:0] icfg_pdrv;
  logic [1:0] icfg_ndrv;
  logic       icfg_wkpu;
  logic       icfg_wkpd;
  logic [7:0] isettle_cnt;
  logic       ocfg_ack, obusy, opad_rstb, odig_rstb, otx_en;
  logic [1:0] oipdrv, oindrv;
  logic [2:0] oirxen;
  logic       otest_weakpu, otest_weakpd;

  aibcr3_iobuf_seq #(.CNT_W(8), .RXEN_OFF(3'b000)) dut (
    .iclk(iclk), .irstb(irstb), .icfg_req(icfg_req),
    .icfg_tx_en(icfg_tx_en), .icfg_rxen(icfg_rxen),
    .icfg_pdrv(icfg_pdrv), .icfg_ndrv(icfg_ndrv),
    .icfg_wkpu(icfg_wkpu), .icfg_wkpd(icfg_wkpd),
    .isettle_cnt(isettle_cnt),
    .ocfg_ack(ocfg_ack), .obusy(obusy),
    .opad_rstb(opad_rstb), .odig_rstb(odig_rstb), .otx_en(otx_en),
    .oipdrv(oipdrv), .oindrv(oindrv), .oirxen(oirxen),
    .otest_weakpu(otest_weakpu), .otest_weakpd(otest_weakpd)
  );

  always #5 iclk = ~iclk;

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  // Output bundle: [13]ack [12]busy [11]pad_rstb [10]dig_rstb [9]tx_en
  //                [8:7]pdrv [6:5]ndrv [4:2]rxen [1]wkpu [0]wkpd
  logic [13:0] obus;
  assign obus = {ocfg_ack, obusy, opad_rstb, odig_rstb, otx_en,
                 oipdrv, oindrv, oirxen, otest_weakpu, otest_weakpd};

  localparam logic [13:0] RST = 14'b0;

  typedef struct {
    int          cyc;
    logic [13:0] v;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [13:0] last_t = RST;

  function automatic logic [13:0] mk(input logic ack, input logic busy,
                                     input logic padr, input logic digr,
                                     input logic tx, input logic [1:0] pd,
                                     input logic [1:0] nd, input logic [2:0] rx,
                                     input logic wu, input logic wd);
    return {ack, busy, padr, digr, tx, pd, nd, rx, wu, wd};
  endfunction

  task automatic push(input int c, input logic [13:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    sb.push_back(e);
  endtask

  // Expected output changes for one accepted request: one change per step,
  // each step n+1 cycles long, first step visible on cycle c0.
  task automatic exp_seq(input int c0, input int n, input logic tx,
                         input logic [2:0] rx, input logic [1:0] pd,
                         input logic [1:0] nd, input logic wu,
                         input logic wd, input bit full);
    int          s;
    logic [13:0] b;
    s = n + 1;
    b = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, wu, wd & ~wu);
    push(c0, b);
    b[11] = 1'b1;
    push(c0 + s, b);
    b[8:7] = pd;
    b[6:5] = nd;
    b[4:2] = rx;
    push(c0 + 2*s, b);
    if (full) begin
      b[9]  = tx;
      b[10] = 1'b1;
      if (tx) b[1:0] = 2'b00;
      push(c0 + 3*s, b);
      b[13] = 1'b1;
      push(c0 + 4*s, b);
      last_t = b;
    end
  endtask

  task automatic issue(input int n, input logic tx, input logic [2:0] rx,
                       input logic [1:0] pd, input logic [1:0] nd,
                       input logic wu, input logic wd, input bit full,
                       output int c0);
    @(negedge iclk);
    icfg_tx_en  = tx;
    icfg_rxen   = rx;
    icfg_pdrv   = pd;
    icfg_ndrv   = nd;
    icfg_wkpu   = wu;
    icfg_wkpd   = wd;
    isettle_cnt = 8'(n);
    icfg_req    = 1'b1;
    c0 = cyc + 1;
    exp_seq(c0, n, tx, rx, pd, nd, wu, wd, full);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge iclk);
  endtask

  // Called on a negedge: req drops, ack and busy fall on the next edge.
  task automatic drop_req();
    logic [13:0] b;
    icfg_req = 1'b0;
    b = last_t;
    b[13] = 1'b0;
    b[12] = 1'b0;
    push(cyc + 1, b);
  endtask

  // Monitor: every change of the output bundle must match the next
  // scoreboard entry, both in value and in the cycle it appears.
  logic [13:0] prev = RST;
  exp_t        got_e;
  always @(negedge iclk) begin
    if (obus !== prev) begin
      n_chk++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_change cyc=%0d got=%b", cyc, obus);
      end else begin
        got_e = sb.pop_front();
        if (got_e.cyc == cyc && obus === got_e.v)
          n_pass++;
        else
          $display("FAIL seq_step got cyc=%0d val=%b, expected cyc=%0d val=%b",
                   cyc, obus, got_e.cyc, got_e.v);
      end
      prev = obus;
    end
  end

  initial begin
    int c0;
    irstb       = 1'b0;
    icfg_req    = 1'b0;
    icfg_tx_en  = 1'b0;
    icfg_rxen   = 3'b000;
    icfg_pdrv   = 2'b00;
    icfg_ndrv   = 2'b00;
    icfg_wkpu   = 1'b0;
    icfg_wkpd   = 1'b0;
    isettle_cnt = 8'd0;

    for (int i = 0; i < 5; i++) begin
      @(negedge iclk);
      n_chk++;
      if (obus === RST) n_pass++;
      else $display("FAIL reset_state got=%b expected=%b", obus, RST);
    end
    irstb = 1'b1;
    wait_to(cyc + 2);

    // N=0, TX on: ack four cycles after acceptance, held while req stays high.
    issue(0, 1'b1, 3'b001, 2'b11, 2'b10, 1'b1, 1'b0, 1'b1, c0);
    wait_to(c0 + 7);
    drop_req();
    wait_to(cyc + 3);

    // Reconfigure from the live state; input changes while busy are ignored
    // and req held past ack does not restart.
    issue(1, 1'b1, 3'b100, 2'b11, 2'b01, 1'b0, 1'b1, 1'b1, c0);
    wait_to(c0 + 1);
    icfg_pdrv  = 2'b01;
    icfg_tx_en = 1'b0;
    icfg_rxen  = 3'b111;
    wait_to(c0 + 12);
    drop_req();
    wait_to(cyc + 3);

    // N=3, TX off, conflicting pulls: pull-up wins and survives TXON.
    issue(3, 1'b0, 3'b010, 2'b01, 2'b01, 1'b1, 1'b1, 1'b1, c0);
    wait_to(c0 + 17);
    drop_req();
    wait_to(cyc + 3);

    // N=5, reset during DRIVE abandons the sequence without an ack.
    issue(5, 1'b1, 3'b011, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0, c0);
    wait_to(c0 + 14);
    #1;
    irstb    = 1'b0;
    icfg_req = 1'b0;
    push(cyc + 1, RST);
    @(negedge iclk);
    @(negedge iclk);
    irstb = 1'b1;
    wait_to(cyc + 20);

    // Fresh request after the aborted one completes normally.
    issue(0, 1'b0, 3'b001, 2'b01, 2'b10, 1'b0, 1'b1, 1'b1, c0);
    wait_to(c0 + 5);
    drop_req();
    wait_to(cyc + 4);

    while (sb.size() != 0) begin
      got_e = sb.pop_front();
      n_chk++;
      $display("FAIL missing_change expected cyc=%0d val=%b, never seen",
               got_e.cyc, got_e.v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
